// File: rtl/out_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : out_sram_pkg
// Description : Shared constants and types for the output-SRAM read-out path.
//               Holds the SRAM geometry, the reader state encoding and the
//               skid-FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
package out_sram_pkg;

    localparam int OSRAM_ADDR_W = 9;
    localparam int OSRAM_DATA_W = 32;
    localparam int OSRAM_DEPTH  = 512;
    localparam int OSRAM_CNT_W  = 10;   // holds 0..OSRAM_DEPTH
    localparam int SKID_DEPTH   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage : out_sram_pkg
`default_nettype wire

// File: rtl/output_sram_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : output_sram_reader_if
// Description : Bundle of the reader's control, SRAM and stream signals.
//   control : start, base_addr, word_cnt  -> busy, done
//   SRAM    : sram_cs, sram_oe, sram_web, sram_a -> ; sram_do <-
//   stream  : m_valid, m_data, m_last -> ; m_ready <-
//   master  : the reader itself; slave : its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface output_sram_reader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_cnt;
    logic              busy;
    logic              done;

    logic              sram_cs;
    logic              sram_oe;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_do;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        input  start, base_addr, word_cnt, sram_do, m_ready,
        output busy, done, sram_cs, sram_oe, sram_web, sram_a,
               m_valid, m_data, m_last
    );

    modport slave (
        output start, base_addr, word_cnt, sram_do, m_ready,
        input  busy, done, sram_cs, sram_oe, sram_web, sram_a,
               m_valid, m_data, m_last
    );
endinterface : output_sram_reader_if
`default_nettype wire

// File: rtl/out_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : out_skid_fifo
// Description : Small register FIFO that absorbs SRAM read latency and stream
//               back-pressure. Head word is presented straight from storage.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : synchronous flush (pointers, count and storage)
//   push_i/push_data_i : write one word (caller guarantees no overflow)
//   pop_i        : remove head word (ignored when empty)
//   count_o, empty_o, head_o : occupancy and head word
// Revision    : 1.0 - initial release
// ============================================================================
module out_skid_fifo #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              pop_ok_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok_d = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Storage is cleared too so the head reads zero after a flush.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_ok_d) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push_i, pop_ok_d})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule : out_skid_fifo
`default_nettype wire

// File: rtl/output_sram_reader.sv
`default_nettype none
// ============================================================================
// Module      : output_sram_reader
// Description : Reads a contiguous run of words from the 512x32 output SRAM
//               and streams them out over valid/ready, with a 3-entry skid
//               FIFO covering read latency and back-pressure.
//   CK, rst     : clock (shared with the SRAM), synchronous active-high reset
//   bus.start/base_addr/word_cnt : run request (sampled only when idle)
//   bus.busy/done               : run status, done is a one-cycle pulse
//   bus.sram_cs/oe/web/a/do     : SRAM read port (1-cycle read latency)
//   bus.m_valid/ready/data/last : output word stream
// Revision    : 1.0 - initial release
// ============================================================================
module output_sram_reader
    import out_sram_pkg::*;
#(
    parameter int ADDR_W = OSRAM_ADDR_W,
    parameter int DATA_W = OSRAM_DATA_W,
    parameter int CNT_W  = OSRAM_CNT_W
) (
    input  logic                 CK,
    input  logic                 rst,
    output_sram_reader_if.master bus
);
    localparam int               c_FCNT_W  = $clog2(SKID_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(OSRAM_DEPTH);

    rd_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  out_cnt_q;
    logic              inflight_q;
    logic              busy_q;
    logic              done_q;

    logic              accept_d;
    logic [CNT_W-1:0]  start_cnt_d;
    logic              cs_d;
    logic              hs_d;
    logic [c_FCNT_W:0] credit_used_d;

    logic [c_FCNT_W-1:0] fifo_count;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_head;

    // busy_q also covers the done cycle, so a start there is ignored as well.
    assign accept_d    = (state_q == IDLE) && !busy_q && bus.start;
    assign start_cnt_d = (bus.word_cnt > c_MAX_CNT) ? c_MAX_CNT : bus.word_cnt;

    // Credits: every issued read needs a guaranteed FIFO slot when it lands.
    assign credit_used_d = {1'b0, fifo_count} + (c_FCNT_W + 1)'(inflight_q);
    assign cs_d = (state_q == RUN) && (issue_cnt_q != '0) &&
                  (credit_used_d < (c_FCNT_W + 1)'(SKID_DEPTH));
    assign hs_d = !fifo_empty && bus.m_ready;

    always_ff @(posedge CK) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= cs_d;
            if (cs_d) begin
                addr_q      <= addr_q + ADDR_W'(1);
                issue_cnt_q <= issue_cnt_q - CNT_W'(1);
            end
            if (hs_d) begin
                out_cnt_q <= out_cnt_q - CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (accept_d) begin
                        busy_q <= 1'b1;
                        if (start_cnt_d == '0) begin
                            // Empty run: a single busy+done cycle, no access.
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            addr_q      <= bus.base_addr;
                            issue_cnt_q <= start_cnt_d;
                            out_cnt_q   <= start_cnt_d;
                        end
                    end
                end
                RUN: begin
                    if (cs_d && (issue_cnt_q == CNT_W'(1))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs_d && (out_cnt_q == CNT_W'(1))) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data for a read issued last cycle is on sram_do now; push it blindly.
    out_skid_fifo #(
        .DEPTH  (SKID_DEPTH),
        .DATA_W (DATA_W),
        .CNT_W  (c_FCNT_W)
    ) u_fifo (
        .clk         (CK),
        .rst         (rst),
        .clr_i       (accept_d),
        .push_i      (inflight_q),
        .push_data_i (bus.sram_do),
        .pop_i       (hs_d),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sram_cs  = cs_d;
    assign bus.sram_oe  = busy_q;
    assign bus.sram_web = 1'b1;
    assign bus.sram_a   = addr_q;
    assign bus.m_valid  = !fifo_empty;
    assign bus.m_data   = fifo_head;
    assign bus.m_last   = !fifo_empty && (out_cnt_q == CNT_W'(1));

endmodule : output_sram_reader
`default_nettype wire
